// File: rtl/pe_cmd_arbiter.sv
// pe_cmd_arbiter: round-robin sharing of the single PE command port, one command in flight, with a done-timeout watchdog
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid_i / req_ready_o       per-requester command handshake (ready is one-hot, IDLE only)
//   req_cmd_i, req_a_i, req_b_i     per-requester command word and operands
//   rsp_valid_o                     one-hot 1-cycle response pulse to the issuing requester
//   rsp_result_o, rsp_err_o         response payload, held between responses
//   pe_cmd_valid_o / pe_cmd_ready_i command handshake toward the PE interface
//   pe_cmd_o, pe_operand_a_o/b_o    latched command and operands toward the PE interface
//   pe_done_i, pe_result_i          result pulse from the PE interface
//   timeout_err_o                   sticky timeout flag, cleared only by reset
module pe_cmd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ-1:0][CMD_WIDTH-1:0]    req_cmd_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    output logic [DATA_WIDTH-1:0]                rsp_result_o,
    output logic                                 rsp_err_o,
    output logic                                 pe_cmd_valid_o,
    output logic [CMD_WIDTH-1:0]                 pe_cmd_o,
    output logic [DATA_WIDTH-1:0]                pe_operand_a_o,
    output logic [DATA_WIDTH-1:0]                pe_operand_b_o,
    input  logic                                 pe_cmd_ready_i,
    input  logic                                 pe_done_i,
    input  logic [DATA_WIDTH-1:0]                pe_result_i,
    output logic                                 timeout_err_o
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       last_q, id_q, winner, idx;
    logic [CMD_WIDTH-1:0]  cmd_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  err_q, sticky_q, any_req, timeout_hit, accept;

    assign any_req     = |req_valid_i;
    assign accept      = (state_q == IDLE) && any_req;
    assign timeout_hit = cnt_q == CNT_W'(TIMEOUT_CYCLES);

    // Scan downward so the set bit closest after last_q is written last and wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(last_q) + i) % NUM_REQ);
            if (req_valid_i[idx]) winner = idx;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_req ? ISSUE : IDLE;
            ISSUE:   state_d = pe_cmd_ready_i ? WAIT : ISSUE;
            WAIT:    state_d = (pe_done_i || timeout_hit) ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst_n so that every output reads 0 while reset is held.
    assign req_ready_o    = (accept && rst_n) ? NUM_REQ'(1) << winner : '0;
    assign rsp_valid_o    = (state_q == RESP) ? NUM_REQ'(1) << id_q : '0;
    assign pe_cmd_valid_o = state_q == ISSUE;
    assign pe_cmd_o       = pe_cmd_valid_o ? cmd_q : '0;
    assign pe_operand_a_o = pe_cmd_valid_o ? a_q : '0;
    assign pe_operand_b_o = pe_cmd_valid_o ? b_q : '0;
    assign rsp_result_o   = res_q;
    assign rsp_err_o      = err_q;
    assign timeout_err_o  = sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= ID_W'(NUM_REQ - 1);
            id_q     <= '0;
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q  <= winner;
                cmd_q <= req_cmd_i[winner];
                a_q   <= req_a_i[winner];
                b_q   <= req_b_i[winner];
            end
            if (state_q == ISSUE) cnt_q <= '0;
            // A done arriving on the timeout cycle still counts as a good result.
            if (state_q == WAIT) begin
                if (pe_done_i) begin
                    res_q <= pe_result_i;
                    err_q <= 1'b0;
                end else if (timeout_hit) begin
                    res_q    <= '0;
                    err_q    <= 1'b1;
                    sticky_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (state_q == RESP) last_q <= id_q;
        end
    end
endmodule

// File: tb/tb_pe_cmd_arbiter.sv
// tb_pe_cmd_arbiter: randomized bench for pe_cmd_arbiter against a round-robin transaction model
module tb_pe_cmd_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0][CW-1:0] req_cmd = '0;
    logic [N-1:0][DW-1:0] req_a = '0;
    logic [N-1:0][DW-1:0] req_b = '0;
    logic [N-1:0] req_ready, rsp_valid;
    logic [DW-1:0] rsp_result, pe_a, pe_b;
    logic [CW-1:0] pe_cmd;
    logic rsp_err, pe_cmd_valid, timeout_err;
    logic pe_ready = 1'b0;
    logic pe_done = 1'b0;
    logic [DW-1:0] pe_result = '0;

    int checks = 0;
    int failures = 0;
    int last_g = N - 1;
    logic [DW-1:0] last_res = '0;
    logic last_err = 1'b0;
    logic sticky = 1'b0;

    pe_cmd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CMD_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_cmd_i(req_cmd), .req_a_i(req_a), .req_b_i(req_b),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
        .pe_cmd_valid_o(pe_cmd_valid), .pe_cmd_o(pe_cmd), .pe_operand_a_o(pe_a), .pe_operand_b_o(pe_b),
        .pe_cmd_ready_i(pe_ready), .pe_done_i(pe_done), .pe_result_i(pe_result),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int o = 1; o <= N; o++) if (m[(last + o) % N]) return (last + o) % N;
        return -1;
    endfunction

    task automatic model_reset();
        last_g = N - 1;
        last_res = '0;
        last_err = 1'b0;
        sticky = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        pe_ready = 1'b0;
        pe_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction starting at an IDLE cycle (called just after a negedge).
    // done_dly < 0 means the PE never answers; noise pulses pe_done while the PE stalls.
    task automatic serve(input string tag, input int rdy_dly, input int done_dly, input bit noise, output int got);
        int id;
        logic [N-1:0] oh;
        logic [CW-1:0] ec;
        logic [DW-1:0] ea, eb, er;
        logic ee;
        got = -1;
        id = rr_pick(req_valid, last_g);
        oh = '0;
        oh[id] = 1'b1;
        ec = req_cmd[id];
        ea = req_a[id];
        eb = req_b[id];
        #1;
        for (int i = 0; i < N; i++) if (req_ready[i]) got = i;
        checks++;
        if (req_ready !== oh || rsp_valid !== '0) begin
            failures++;
            $display("FAIL %s accept: ready=%b rsp_valid=%b expected ready=%b rsp_valid=0", tag, req_ready, rsp_valid, oh);
        end
        checks++;
        if (rsp_result !== last_res || rsp_err !== last_err || timeout_err !== sticky) begin
            failures++;
            $display("FAIL %s hold: result=%h err=%b sticky=%b expected %h %b %b", tag, rsp_result, rsp_err, timeout_err, last_res, last_err, sticky);
        end
        @(negedge clk);
        req_cmd[id] = $urandom;
        req_a[id] = $urandom;
        req_b[id] = $urandom;
        for (int k = 0; k <= rdy_dly; k++) begin
            pe_ready = (k == rdy_dly);
            pe_done = noise && (k < rdy_dly);
            #1;
            checks++;
            if (pe_cmd_valid !== 1'b1 || pe_cmd !== ec || pe_a !== ea || pe_b !== eb || req_ready !== '0 || rsp_valid !== '0) begin
                failures++;
                $display("FAIL %s issue%0d: valid=%b cmd=%h a=%h b=%h ready=%b expected 1 %h %h %h 0", tag, k, pe_cmd_valid, pe_cmd, pe_a, pe_b, req_ready, ec, ea, eb);
            end
            @(negedge clk);
        end
        pe_ready = 1'b0;
        pe_done = 1'b0;
        ee = done_dly < 0;
        er = ee ? '0 : ea * eb;
        for (int k = 0; k <= (ee ? TO : done_dly); k++) begin
            pe_done = !ee && (k == done_dly);
            pe_result = pe_done ? ea * eb : DW'($urandom);
            #1;
            checks++;
            if (rsp_valid !== '0 || pe_cmd_valid !== 1'b0 || req_ready !== '0) begin
                failures++;
                $display("FAIL %s wait%0d: rsp_valid=%b cmd_valid=%b ready=%b expected all 0", tag, k, rsp_valid, pe_cmd_valid, req_ready);
            end
            @(negedge clk);
        end
        pe_done = 1'b0;
        if (ee) sticky = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== oh || rsp_result !== er || rsp_err !== ee || timeout_err !== sticky) begin
            failures++;
            $display("FAIL %s resp: valid=%b result=%h err=%b sticky=%b expected %b %h %b %b", tag, rsp_valid, rsp_result, rsp_err, timeout_err, oh, er, ee, sticky);
        end
        last_g = id;
        last_res = er;
        last_err = ee;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_result !== '0 || rsp_err !== 1'b0 || pe_cmd_valid !== 1'b0 || pe_cmd !== '0 || pe_a !== '0 || pe_b !== '0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset: ready=%b rsp=%b res=%h err=%b cv=%b te=%b expected all 0", req_ready, rsp_valid, rsp_result, rsp_err, pe_cmd_valid, timeout_err);
        end
        do_reset();
    endtask

    task automatic test_single();
        int got;
        req_cmd[0] = 32'h0000_00A5;
        req_a[0] = 3;
        req_b[0] = 5;
        req_valid = 4'b0001;
        serve("single", 0, 0, 1'b0, got);
        req_valid = '0;
        checks++;
        if (last_res !== 32'd15 || got !== 0) begin
            failures++;
            $display("FAIL single_result: model_result=%0d grant=%0d expected 15 0", last_res, got);
        end
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0) begin
            failures++;
            $display("FAIL single_idle: ready=%b rsp=%b expected 0 0", req_ready, rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int got;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve("rr", 0, 0, 1'b0, got);
            checks++;
            if (got !== order[i]) begin
                failures++;
                $display("FAIL rr_order%0d: grant=%0d expected %0d", i, got, order[i]);
            end
        end
    endtask

    task automatic test_priority_skip();
        int got;
        req_valid = 4'b0100;
        serve("skip_pre", 0, 1, 1'b0, got);
        req_valid = 4'b1010;
        serve("skip3", 0, 0, 1'b0, got);
        checks++;
        if (got !== 3) begin
            failures++;
            $display("FAIL skip_first: grant=%0d expected 3", got);
        end
        serve("skip1", 0, 0, 1'b0, got);
        checks++;
        if (got !== 1) begin
            failures++;
            $display("FAIL skip_second: grant=%0d expected 1", got);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int got;
        req_valid = 4'b0110;
        serve("bp", 5, 2, 1'b1, got);
        serve("bp2", 3, 0, 1'b1, got);
        req_valid = '0;
        pe_done = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL idle_done: ready=%b expected 0", req_ready);
        end
        @(negedge clk);
        pe_done = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== '0 || pe_cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_done_ignored: rsp=%b cv=%b expected 0 0", rsp_valid, pe_cmd_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int got;
        req_valid = 4'b1000;
        serve("to_edge", 0, TO, 1'b0, got);
        serve("to", 0, -1, 1'b0, got);
        serve("to_after", 1, 0, 1'b0, got);
        serve("to_near", 0, TO - 1, 1'b0, got);
        req_valid = '0;
    endtask

    task automatic test_random();
        int got, r, dd;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                req_cmd[i] = $urandom;
                req_a[i] = $urandom;
                req_b[i] = $urandom;
            end
            req_valid = N'($urandom_range(0, 15));
            if (req_valid == '0) begin
                pe_done = $urandom_range(0, 1) == 1;
                #1;
                checks++;
                if (req_ready !== '0 || rsp_valid !== '0 || pe_cmd_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_idle%0d: ready=%b rsp=%b cv=%b expected 0", it, req_ready, rsp_valid, pe_cmd_valid);
                end
                @(negedge clk);
                pe_done = 1'b0;
            end else begin
                r = $urandom_range(0, 9);
                dd = (r == 0) ? -1 : (r == 1) ? TO : $urandom_range(0, 3);
                serve("rand", $urandom_range(0, 3), dd, $urandom_range(0, 1) == 1, got);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        int got;
        req_valid = 4'b1111;
        @(negedge clk);
        pe_ready = 1'b1;
        @(negedge clk);
        pe_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_result !== '0 || rsp_err !== 1'b0 || pe_cmd_valid !== 1'b0 || pe_cmd !== '0 || pe_a !== '0 || pe_b !== '0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: ready=%b rsp=%b res=%h err=%b cv=%b te=%b expected all 0", req_ready, rsp_valid, rsp_result, rsp_err, pe_cmd_valid, timeout_err);
        end
        model_reset();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pe_done = 1'b1;
            #1;
            checks++;
            if (rsp_valid !== '0 || pe_cmd_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale%0d: rsp=%b cv=%b expected 0 0", k, rsp_valid, pe_cmd_valid);
            end
            @(negedge clk);
        end
        pe_done = 1'b0;
        req_valid = 4'b1111;
        serve("post_reset", 0, 0, 1'b0, got);
        checks++;
        if (got !== 0) begin
            failures++;
            $display("FAIL post_reset_grant: grant=%0d expected 0", got);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_priority_skip();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
